// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit processor: fetch, decode, execute,
// data-memory handshake and register writeback, one instruction in flight.
module alu_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    output logic [3:0]  rfRaddr1,
    output logic [3:0]  rfRaddr2,
    input  logic [15:0] rfRdata1,
    input  logic [15:0] rfRdata2,
    output logic        rfWe,
    output logic [3:0]  rfWaddr,
    output logic [15:0] rfWdata,
    output logic [3:0]  ALUselect,
    output logic [15:0] ALUin1,
    output logic [15:0] ALUin2,
    input  logic [15:0] ALUout,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    input  logic [15:0] memRdata,
    input  logic        memAck,
    output logic        halted,
    output logic        illegalOp,
    output logic [15:0] retired
);
    localparam int unsigned W = 16;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LI   = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;
    localparam logic [3:0] OP_BEQ  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
    } state_t;

    state_t       state, next_state;
    logic [W-1:0] pc, ir, opa, opb, result;
    logic [W-1:0] branch_off, in2_d;
    logic [3:0]   op, rd, fetch_op, sel_d;
    logic         illegal, mem_req_d, mem_we_d, rf_we_d, halted_d, illegal_d;

    assign op         = ir[15:12];
    assign rd         = ir[11:8];
    assign fetch_op   = imemData[15:12];
    assign illegal    = (op >= 4'd10) && (op <= 4'd14);
    assign branch_off = {{12{ir[3]}}, ir[3:0]};

    // Result, operand and instruction registers feed the outward buses directly.
    assign imemAddr = pc;
    assign rfWaddr  = rd;
    assign rfWdata  = result;
    assign memAddr  = result;
    assign memWdata = opb;
    assign ALUin1   = opa;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     next_state = S_DECODE;
            S_DECODE: begin
                if (illegal)              next_state = S_FETCH;
                else if (op == OP_HALT)   next_state = S_HALT;
                else                      next_state = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (op == OP_BEQ)                        next_state = S_FETCH;
                else if (op == OP_LW || op == OP_SW)     next_state = S_MEM;
                else                                     next_state = S_WRITEBACK;
            end
            S_MEM: begin
                if (memAck) next_state = (op == OP_LW) ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    // Next values of the registered control outputs, aligned with next_state.
    always_comb begin
        mem_req_d = (next_state == S_MEM);
        mem_we_d  = mem_req_d && (op == OP_SW);
        rf_we_d   = (next_state == S_WRITEBACK);
        halted_d  = (next_state == S_HALT);
        illegal_d = (state == S_DECODE) && illegal;
        sel_d     = ALUselect;
        in2_d     = ALUin2;
        if (state == S_DECODE) begin
            sel_d = (op <= OP_SW) ? op : 4'd0;
            case (op)
                OP_ADDI, OP_LW, OP_SW: in2_d = W'(ir[3:0]);
                OP_LI:                 in2_d = W'(ir[7:0]);
                default:               in2_d = rfRdata2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            rfWe      <= 1'b0;
            halted    <= 1'b0;
            illegalOp <= 1'b0;
            ALUselect <= 4'd0;
            ALUin2    <= '0;
        end else begin
            memReq    <= mem_req_d;
            memWe     <= mem_we_d;
            rfWe      <= rf_we_d;
            halted    <= halted_d;
            illegalOp <= illegal_d;
            ALUselect <= sel_d;
            ALUin2    <= in2_d;
        end
    end

    // Datapath: instruction, operands, result, PC and retire count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            retired  <= '0;
            ir       <= '0;
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            rfRaddr1 <= 4'd0;
            rfRaddr2 <= 4'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir       <= imemData;
                    rfRaddr1 <= imemData[7:4];
                    rfRaddr2 <= (fetch_op == OP_SW || fetch_op == OP_BEQ) ? imemData[11:8]
                                                                          : imemData[3:0];
                end
                S_DECODE: begin
                    opa <= rfRdata1;
                    opb <= rfRdata2;
                    if (illegal) begin
                        pc      <= pc + W'(1);
                        retired <= retired + W'(1);
                    end else if (op == OP_HALT) begin
                        retired <= retired + W'(1);
                    end
                end
                S_EXECUTE: begin
                    result <= ALUout;
                    if (op == OP_BEQ) begin
                        pc      <= (opa == opb) ? pc + W'(1) + branch_off : pc + W'(1);
                        retired <= retired + W'(1);
                    end
                end
                S_MEM: begin
                    if (memAck) begin
                        if (op == OP_LW) begin
                            result <= memRdata;
                        end else begin
                            pc      <= pc + W'(1);
                            retired <= retired + W'(1);
                        end
                    end
                end
                S_WRITEBACK: begin
                    pc      <= pc + W'(1);
                    retired <= retired + W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: memories, register file and ALU around the DUT, with an
// instruction-level reference model checking every retired instruction.
module tb_alu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] imemAddr, imemData, rfRdata1, rfRdata2, rfWdata;
    logic [3:0]  rfRaddr1, rfRaddr2, rfWaddr, ALUselect;
    logic        rfWe, memReq, memWe, memAck, halted, illegalOp;
    logic [15:0] ALUin1, ALUin2, ALUout, memAddr, memWdata, memRdata, retired;

    alu_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imemAddr(imemAddr), .imemData(imemData),
        .rfRaddr1(rfRaddr1), .rfRaddr2(rfRaddr2),
        .rfRdata1(rfRdata1), .rfRdata2(rfRdata2),
        .rfWe(rfWe), .rfWaddr(rfWaddr), .rfWdata(rfWdata),
        .ALUselect(ALUselect), .ALUin1(ALUin1), .ALUin2(ALUin2), .ALUout(ALUout),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .halted(halted), .illegalOp(illegalOp), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [15:0] imem     [256];
    logic [15:0] rf       [16];
    logic [15:0] dmem     [256];
    logic [15:0] init_rf  [16];
    logic [15:0] init_mem [256];
    logic        load = 1'b0;
    logic        noise = 1'b0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    assign imemData = imem[imemAddr[7:0]];
    assign rfRdata1 = rf[rfRaddr1];
    assign rfRdata2 = rf[rfRaddr2];
    assign memRdata = dmem[memAddr[7:0]];
    assign memAck   = memReq ? (ack_cnt == ack_delay) : noise;

    // External ALU
    always_comb begin
        case (ALUselect)
            4'd1:    ALUout = ALUin1 << ALUin2;
            4'd2:    ALUout = ALUin1 >> ALUin2;
            4'd3:    ALUout = ALUin1 | ALUin2;
            4'd4:    ALUout = ALUin1 & ALUin2;
            4'd6:    ALUout = ALUin2;
            default: ALUout = ALUin1 + ALUin2;
        endcase
    end

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ack_cnt <= (memReq && !memAck) ? ack_cnt + 1 : 0;
        if (load) begin
            for (int i = 0; i < 16; i++)  rf[i]   <= init_rf[i];
            for (int i = 0; i < 256; i++) dmem[i] <= init_mem[i];
        end else begin
            if (rfWe) rf[rfWaddr] <= rfWdata;
            if (memReq && memAck && memWe) dmem[memAddr[7:0]] <= memWdata;
        end
    end

    // Stray acks outside a request must be ignored by the sequencer.
    always @(negedge clk) noise <= 1'($urandom_range(1, 0));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (model pc %0h)", tag, got, exp, m_pc);
        end
    endtask

    // Reference model state and the expectations for the instruction being run.
    logic [15:0] m_pc, m_ret;
    logic [15:0] m_rf  [16];
    logic [15:0] m_mem [256];
    int          e_lat;
    logic [3:0]  e_sel, e_dest;
    logic [15:0] e_val, e_addr;
    logic        e_exec, e_we, e_mem, e_sw, e_ill, e_halt, prev_ill;

    task automatic model_step(input int wt);
        logic [15:0] ins, a, b, ea, res;
        int op, off;
        ins = imem[m_pc[7:0]];
        op  = int'(ins[15:12]);
        a   = m_rf[ins[7:4]];
        b   = m_rf[ins[3:0]];
        ea  = a + 16'(ins[3:0]);
        res = 16'h0;
        e_lat = 4; e_exec = 1'b1; e_we = 1'b0; e_mem = 1'b0; e_sw = 1'b0;
        e_ill = 1'b0; e_halt = 1'b0; e_sel = 4'(op); e_dest = ins[11:8];
        e_val = 16'h0; e_addr = 16'h0;
        if (op <= 6) begin
            case (op)
                0: res = a + b;
                1: res = a << b;
                2: res = a >> b;
                3: res = a | b;
                4: res = a & b;
                5: res = a + 16'(ins[3:0]);
                default: res = 16'(ins[7:0]);
            endcase
            e_we = 1'b1; e_val = res; m_rf[e_dest] = res; m_pc = m_pc + 16'd1;
        end else if (op == 7) begin
            e_lat = 5 + wt; e_mem = 1'b1; e_addr = ea; e_we = 1'b1;
            e_val = m_mem[ea[7:0]]; m_rf[e_dest] = e_val; m_pc = m_pc + 16'd1;
        end else if (op == 8) begin
            e_lat = 4 + wt; e_mem = 1'b1; e_sw = 1'b1; e_addr = ea;
            e_val = m_rf[e_dest]; m_mem[ea[7:0]] = e_val; m_pc = m_pc + 16'd1;
        end else if (op == 9) begin
            e_lat = 3; e_sel = 4'd0;
            off = ins[3] ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
            if (m_rf[e_dest] == a) m_pc = 16'(int'(m_pc) + 1 + off);
            else                   m_pc = m_pc + 16'd1;
        end else if (op == 15) begin
            e_lat = 2; e_exec = 1'b0; e_halt = 1'b1;
        end else begin
            e_lat = 2; e_exec = 1'b0; e_ill = 1'b1; m_pc = m_pc + 16'd1;
        end
        m_ret = m_ret + 16'd1;
    endtask

    // Run one instruction from its FETCH cycle to its retirement, watching the buses.
    task automatic run_instr(input int wt);
        int k, we_cnt, req_cnt, ill_cnt;
        logic [15:0] old_ret, w_val, q_addr, q_wdata;
        logic [3:0]  sel, w_addr;
        logic        q_we;
        ack_delay = wt;
        model_step(wt);
        old_ret = retired;
        k = 0; we_cnt = 0; req_cnt = 0; ill_cnt = 0;
        w_val = 16'h0; q_addr = 16'h0; q_wdata = 16'h0; sel = 4'd0; w_addr = 4'd0; q_we = 1'b0;
        while (retired == old_ret && k < 40) begin
            if (k == 2) sel = ALUselect;
            if (rfWe) begin we_cnt++; w_addr = rfWaddr; w_val = rfWdata; end
            if (memReq) begin req_cnt++; q_addr = memAddr; q_we = memWe; q_wdata = memWdata; end
            if (illegalOp) ill_cnt++;
            @(negedge clk);
            k++;
        end
        check_eq("latency", 32'(k), 32'(e_lat));
        check_eq("pc", 32'(imemAddr), 32'(m_pc));
        check_eq("retired", 32'(retired), 32'(m_ret));
        check_eq("rf_we_pulses", 32'(we_cnt), e_we ? 32'd1 : 32'd0);
        check_eq("mem_req_cycles", 32'(req_cnt), e_mem ? 32'(wt + 1) : 32'd0);
        check_eq("illegal_pulses", 32'(ill_cnt), prev_ill ? 32'd1 : 32'd0);
        if (e_exec) check_eq("alu_select", 32'(sel), 32'(e_sel));
        if (e_we) begin
            check_eq("rf_waddr", 32'(w_addr), 32'(e_dest));
            check_eq("rf_wdata", 32'(w_val), 32'(e_val));
        end
        if (e_mem) begin
            check_eq("mem_addr", 32'(q_addr), 32'(e_addr));
            check_eq("mem_we", 32'(q_we), 32'(e_sw));
        end
        if (e_sw)   check_eq("mem_wdata", 32'(q_wdata), 32'(e_val));
        if (e_halt) check_eq("halted", 32'(halted), 32'd1);
        prev_ill = e_ill;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load  = 1'b0;
        m_pc = 16'h0000; m_ret = 16'h0000; prev_ill = 1'b0; e_halt = 1'b0;
        for (int i = 0; i < 16; i++)  m_rf[i]  = init_rf[i];
        for (int i = 0; i < 256; i++) m_mem[i] = init_mem[i];
        check_eq("rst_pc", 32'(imemAddr), 32'h0);
        check_eq("rst_retired", 32'(retired), 32'h0);
        check_eq("rst_ctrl", {27'h0, memReq, memWe, rfWe, halted, illegalOp}, 32'h0);
    endtask

    task automatic idle_check();
        int busy;
        busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (rfWe || memReq || memWe) busy++;
        end
        check_eq("halt_idle", 32'(busy), 32'h0);
        check_eq("halt_pc", 32'(imemAddr), 32'(m_pc));
        check_eq("halt_retired", 32'(retired), 32'(m_ret));
        check_eq("halt_flag", 32'(halted), 32'h1);
    endtask

    task automatic directed();
        int steps;
        logic [15:0] prog [19] = '{
            16'h6105, 16'h6203, 16'h0312, 16'h6101, 16'h6204, 16'h1412, 16'h2542,
            16'h6210, 16'h1412, 16'h6180, 16'h0111, 16'h7612, 16'h8610, 16'h6734,
            16'h6833, 16'h5881, 16'h978E, 16'hA123, 16'hF000};
        for (int i = 0; i < 256; i++) begin imem[i] = 16'hF000; init_mem[i] = 16'h0; end
        for (int i = 0; i < 16; i++)  init_rf[i] = 16'h0;
        for (int i = 0; i < 19; i++)  imem[i] = prog[i];
        init_mem[2] = 16'hBEEF;
        do_reset();
        steps = 0;
        while (!e_halt && steps < 30) begin
            run_instr(m_pc == 16'd11 ? 3 : 0);
            steps++;
        end
        check_eq("dir_r3_add", 32'(rf[3]), 32'h0008);
        check_eq("dir_r5_shr", 32'(rf[5]), 32'h0001);
        check_eq("dir_r4_shl16", 32'(rf[4]), 32'h0000);
        check_eq("dir_r6_lw", 32'(rf[6]), 32'hBEEF);
        check_eq("dir_sw_mem", 32'(dmem[0]), 32'hBEEF);
        check_eq("dir_r8_loop", 32'(rf[8]), 32'h0035);
        check_eq("dir_steps", 32'(steps), 32'd21);
        idle_check();
    endtask

    task automatic reset_mid_mem();
        int k;
        imem[0] = 16'h6140;
        imem[1] = 16'h7210;
        init_rf[2] = 16'h1234;
        do_reset();
        run_instr(0);
        ack_delay = 20;
        k = 0;
        while (!memReq && k < 10) begin @(negedge clk); k++; end
        check_eq("mid_mem_req", 32'(memReq), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_ctrl", {27'h0, memReq, memWe, rfWe, halted, illegalOp}, 32'h0);
        check_eq("mid_rst_pc", 32'(imemAddr), 32'h0);
        check_eq("mid_rst_retired", 32'(retired), 32'h0);
        check_eq("mid_rst_alu", {12'h0, ALUselect, ALUin1}, 32'h0);
        check_eq("mid_rst_in2", 32'(ALUin2), 32'h0);
        check_eq("mid_rst_bus", {memAddr, rfWdata}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_abandoned", 32'(rf[2]), 32'h1234);
    endtask

    task automatic random_runs();
        int steps;
        logic [3:0] op;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) begin
                op = 4'($urandom_range(15, 0));
                if (op == 4'd15 && $urandom_range(19, 0) != 0) op = 4'd0;
                imem[i]     = {op, 12'($urandom)};
                init_mem[i] = 16'($urandom);
            end
            for (int i = 0; i < 16; i++) init_rf[i] = 16'($urandom_range(7, 0) == 0 ? 16 : $urandom);
            do_reset();
            steps = 0;
            while (!e_halt && steps < 80) begin
                run_instr($urandom_range(3, 0));
                steps++;
            end
            if (e_halt) idle_check();
        end
    endtask

    initial begin
        directed();
        reset_mid_mem();
        random_runs();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
